// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - sequential single-MAC FIR filter with saturating or wrapping output
// One multiply-accumulate per cycle over TAPS taps, then a finishing cycle that registers the result.
module fir_mac_engine #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 64,
  parameter int OUT_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     overflow
);

  localparam int AW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + AW;
  localparam int EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state;
  logic signed [COEF_W-1:0]  coef [TAPS];
  logic signed [DATA_W-1:0]  d    [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [AW-1:0]             cnt;
  logic                      drain;
  logic signed [PROD_W-1:0]  prod;
  logic signed [EXT_W-1:0]   acc_ext;
  logic [OUT_W-1:0]          res;
  logic                      res_ovf;

  assign prod     = PROD_W'(d[cnt]) * PROD_W'(coef[cnt]);
  assign acc_ext  = EXT_W'(acc);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Clamp or truncate the finished accumulator into the output width.
  always_comb begin
    res     = acc_ext[OUT_W-1:0];
    res_ovf = 1'b0;
    if (SAT_EN != 0) begin
      if (acc_ext > MAX_V) begin
        res     = {1'b0, {(OUT_W-1){1'b1}}};
        res_ovf = 1'b1;
      end else if (acc_ext < MIN_V) begin
        res     = {1'b1, {(OUT_W-1){1'b0}}};
        res_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      drain     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        d[k]    <= '0;
        coef[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_we) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            d[0] <= in_data;
            for (int k = 1; k < TAPS; k++) d[k] <= d[k-1];
            acc   <= '0;
            cnt   <= '0;
            drain <= 1'b0;
            state <= MAC;
          end
        end
        MAC: begin
          // The extra drain cycle lets the last product settle into acc before clamping.
          if (!drain) begin
            acc <= acc + ACC_W'(prod);
            if (cnt == AW'(TAPS-1)) drain <= 1'b1;
            else                    cnt   <= cnt + 1'b1;
          end else begin
            out_data  <= res;
            overflow  <= res_ovf;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine (TAPS=4)
// Saturating and wrapping instances share stimulus; results are compared with tables and a sum-of-products model.
module tb_fir_mac_engine;
  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        reset, coef_we, in_valid, out_ready;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data, in_data;
  logic        in_ready, out_valid, busy, overflow;
  logic [31:0] out_data;
  logic        in_ready_w, out_valid_w, busy_w, overflow_w;
  logic [31:0] out_data_w;

  always #5 clk = ~clk;

  fir_mac_engine #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32), .SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .overflow(overflow));

  fir_mac_engine #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32), .SAT_EN(0)) dut_w (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .out_valid(out_valid_w), .out_data(out_data_w), .out_ready(out_ready),
    .busy(busy_w), .overflow(overflow_w));

  int tests = 0;
  int fails = 0;
  logic signed [15:0] m_coef [TAPS];
  logic signed [15:0] m_d    [TAPS];

  typedef struct {
    bit          rst;
    bit          load;
    logic [15:0] c0, c1, c2, c3;
    logic [15:0] x;
    logic [31:0] es;
    bit          eo;
    logic [31:0] ew;
  } vec_t;
  vec_t vt [13];

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic longint model_sum();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(m_d[k]) * longint'(m_coef[k]);
    return s;
  endfunction

  function automatic logic [31:0] model_sat(input longint s);
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic bit model_ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = '0;
      m_d[k]    = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; coef_we = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data_w", out_data_w, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);
    model_clear();
  endtask

  task automatic write_coef(input int a, input logic [15:0] v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a[1:0]; coef_data = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    m_coef[a] = v;
  endtask

  task automatic run_sample(input logic [15:0] x, input int hold, input bit we_acc, input bit we_mac,
                            input logic [1:0] wa, input logic [15:0] wd,
                            output logic [31:0] rs, output logic ro, output logic [31:0] rw);
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = x; out_ready = (hold == 0);
    coef_we = we_acc; coef_addr = wa; coef_data = wd;
    @(posedge clk);
    for (int k = TAPS-1; k > 0; k--) m_d[k] = m_d[k-1];
    m_d[0] = x;
    if (we_acc) m_coef[wa] = wd;
    #1;
    in_valid = 1'b0; coef_we = we_mac;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      coef_we = 1'b0;
      lat++;
      if (lat == 2) check("busy_mac", busy, 1);
    end
    check("latency", lat, 5);
    check("in_ready_out", in_ready, 0);
    check("wrap_ovf", overflow_w, 0);
    rs = out_data; ro = overflow; rw = out_data_w;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 16'h1234;
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, rs);
      check("bp_ovf", overflow, ro);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("ret_idle", out_valid, 0);
    check("ret_in_ready", in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rs, rw;
    logic        ro;
    longint      s;
    int          seen;
    logic [15:0] x, wd;
    logic [1:0]  wa;
    bit          wacc;
    int          hold;

    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_clear();

    vt[0]  = '{1, 1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 32'd1, 0, 32'd1};
    vt[1]  = '{0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd2, 0, 32'd2};
    vt[2]  = '{0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd3, 0, 32'd3};
    vt[3]  = '{0, 0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd4, 0, 32'd4};
    vt[4]  = '{1, 1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 0, 32'h3FFF0001};
    vt[5]  = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h7FFE0002, 0, 32'h7FFE0002};
    vt[6]  = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h7FFFFFFF, 1, 32'hBFFD0003};
    vt[7]  = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h7FFFFFFF, 1, 32'hFFFC0004};
    vt[8]  = '{1, 1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h8000, 32'h00008000, 0, 32'h00008000};
    vt[9]  = '{1, 1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 32'hC0008000, 0, 32'hC0008000};
    vt[10] = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h80010000, 0, 32'h80010000};
    vt[11] = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h80000000, 1, 32'h40018000};
    vt[12] = '{0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 32'h80000000, 1, 32'h00020000};

    for (int i = 0; i < 13; i++) begin
      if (vt[i].rst) do_reset();
      if (vt[i].load) begin
        write_coef(0, vt[i].c0); write_coef(1, vt[i].c1);
        write_coef(2, vt[i].c2); write_coef(3, vt[i].c3);
      end
      run_sample(vt[i].x, 0, 0, 0, 2'd0, 16'd0, rs, ro, rw);
      check($sformatf("vec%0d_sat", i), rs, vt[i].es);
      check($sformatf("vec%0d_ovf", i), ro, vt[i].eo);
      check($sformatf("vec%0d_wrap", i), rw, vt[i].ew);
    end

    // Backpressure: junk samples offered while held in OUT must not enter the delay line.
    do_reset();
    write_coef(0, 16'd1); write_coef(1, 16'd2); write_coef(2, 16'd3); write_coef(3, 16'd4);
    run_sample(16'd5, 6, 0, 0, 2'd0, 16'd0, rs, ro, rw);
    check("bp_result", rs, 32'd5);
    run_sample(16'd0, 0, 0, 0, 2'd0, 16'd0, rs, ro, rw);
    check("bp_not_consumed", rs, 32'd10);

    // Coefficient write in MAC is dropped; the same write alongside an accept takes effect.
    do_reset();
    write_coef(0, 16'd5);
    run_sample(16'd3, 0, 0, 1, 2'd0, 16'd9, rs, ro, rw);
    check("we_mac_ignored", rs, 32'd15);
    run_sample(16'd2, 0, 1, 0, 2'd0, 16'd9, rs, ro, rw);
    check("we_accept_used", rs, 32'd18);

    // Mid-pass reset on the second MAC cycle.
    do_reset();
    write_coef(0, 16'd1); write_coef(1, 16'd2); write_coef(2, 16'd3); write_coef(3, 16'd4);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'd1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_pulse", seen, 0);
    run_sample(16'd1, 0, 0, 0, 2'd0, 16'd0, rs, ro, rw);
    check("abort_zero_coef", rs, 32'd0);

    // Randomized traffic against the sum-of-products model.
    do_reset();
    for (int k = 0; k < TAPS; k++) begin
      case ($urandom_range(0, 2))
        0:       wd = 16'h7FFF;
        1:       wd = 16'h8000;
        default: wd = 16'($urandom);
      endcase
      write_coef(k, wd);
    end
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      wacc = ($urandom_range(0, 4) == 0);
      wa   = 2'($urandom);
      wd   = 16'($urandom);
      run_sample(x, hold, wacc, ($urandom_range(0, 3) == 0), wa, wd, rs, ro, rw);
      s = model_sum();
      check($sformatf("rnd%0d_sat", n), rs, model_sat(s));
      check($sformatf("rnd%0d_ovf", n), ro, model_ovf(s));
      check($sformatf("rnd%0d_wrap", n), rw, s[31:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the signed sample width.
REQ-002 The block SHALL have parameter COEF_W, default 16, meaning the signed coefficient width.
REQ-003 The block SHALL have parameter TAPS, default 64, meaning the filter length; legal values are 2 to 256.
REQ-004 The block SHALL have parameter OUT_W, default 32, meaning the signed result width.
REQ-005 The block SHALL have parameter SAT_EN, default 1: 1 selects saturating output, 0 selects wrapping output.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have ports coef_we (input, 1), coef_addr (input, clog2(TAPS)), coef_data (input, COEF_W): the coefficient write port.
REQ-009 The block SHALL have ports in_valid (input, 1), in_data (input, DATA_W), in_ready (output, 1): the sample input handshake.
REQ-010 The block SHALL have ports out_valid (output, 1), out_data (output, OUT_W), out_ready (input, 1): the result output handshake.
REQ-011 The block SHALL have ports busy (output, 1), meaning the FSM is not IDLE, and overflow (output, 1), meaning the current result was clamped.

Function
REQ-012 The block SHALL hold TAPS signed coefficients coef[0..TAPS-1] and a TAPS-entry signed delay line d[0..TAPS-1].
REQ-013 The FSM SHALL have three states: IDLE, MAC and OUT.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 Accept (in_valid & in_ready) SHALL shift the delay line, with d[k] <= d[k-1] and d[0] <= in_data, clear the accumulator, zero the tap counter and enter MAC.
REQ-016 In MAC, each cycle SHALL perform acc += d[cnt]*coef[cnt] and cnt++; after the cycle with cnt == TAPS-1 the FSM SHALL enter OUT.
REQ-017 The accumulator width SHALL be DATA_W+COEF_W+clog2(TAPS) bits, signed; no intermediate overflow is permitted.
REQ-018 out_valid SHALL be 1 exactly in OUT; the first out_valid cycle SHALL be TAPS+1 cycles after the accept edge.
REQ-019 With SAT_EN=1, out_data SHALL be acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and overflow SHALL be 1 when clamping occurred.
REQ-020 With SAT_EN=0, out_data SHALL be the low OUT_W bits of acc, and overflow SHALL be 0.
REQ-021 out_data and overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 out_valid & out_ready SHALL return the FSM to IDLE on that edge; a new sample is therefore accepted at the earliest on the next edge.
REQ-023 coef_we SHALL write coef[coef_addr] <= coef_data only in IDLE; writes in MAC or OUT SHALL be ignored.
REQ-024 coef_we and accept on the same IDLE edge SHALL both commit, and the new coefficient SHALL be used by that MAC pass.
REQ-025 in_valid outside IDLE SHALL be ignored, with no shift and no state change.
REQ-026 busy SHALL be 1 in MAC and OUT.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and clear the accumulator, the counter, all d[] and all coef[] to 0.
REQ-028 Outputs during and after reset SHALL be: in_ready=1 (once reset is low), out_valid=0, out_data=0, overflow=0, busy=0.
REQ-029 Reset in MAC or OUT SHALL abort the pass with no out_valid pulse; reset SHALL take priority over coef_we and in_valid.

Verification (TAPS=4, DATA_W=COEF_W=16, OUT_W=32, SAT_EN=1 unless stated)
REQ-030 Impulse: coef={1,2,3,4}, samples 1,0,0,0 -> out_data 1,2,3,4; each out_valid arrives 5 cycles after its accept.
REQ-031 Backpressure: hold out_ready=0 for 6 cycles in OUT -> out_valid, out_data and overflow stay constant, in_ready=0, and a presented in_valid is not consumed.
REQ-032 Saturation: all coef=0x7FFF, four samples 0x7FFF -> last out_data=0x7FFFFFFF and overflow=1; with SAT_EN=0 the same stimulus gives out_data=0xFFFC0004 and overflow=0.
REQ-033 Coefficient write during MAC: coef_we to addr 0 with value 9 in the MAC state -> result uses the old coef[0]; the write is repeated in IDLE together with accept -> result uses 9.
REQ-034 Mid-pass reset: assert reset on the 2nd MAC cycle -> no out_valid, busy=0, in_ready=1; the next impulse with unloaded coefficients gives out_data=0.
REQ-035 Negative arithmetic: coef={-1,0,0,0}, sample 0x8000 -> out_data=0x00008000 and overflow=0.
